// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone-to-asynchronous-SRAM bridge.
package wb_sram_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StWriteHold,
        StDone
    } state_t;

    localparam int unsigned WAIT_CYCLES_MIN = 1;
    localparam int unsigned WAIT_CYCLES_MAX = 7;

endpackage

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave driving an asynchronous SRAM with fixed-length strobes.
// All outputs are registered; each output's next value is decoded from the next state.
module wb_sram_slave
    import wb_sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SRAM_ADDR_WIDTH = 20,
    parameter int unsigned WAIT_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [ADDR_WIDTH-1:0]      wb_adr_i,
    input  logic [DATA_WIDTH-1:0]      wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]    wb_sel_i,
    output logic                       wb_ack_o,
    output logic [DATA_WIDTH-1:0]      wb_dat_o,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0]      sram_data_i,
    output logic [DATA_WIDTH-1:0]      sram_data_o,
    output logic                       sram_data_oe,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    output logic                       sram_we_n,
    output logic [DATA_WIDTH/8-1:0]    sram_be_n
);

    if (WAIT_CYCLES < WAIT_CYCLES_MIN || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait
        $error("wb_sram_slave: WAIT_CYCLES out of range");
    end

    localparam logic [2:0] LastCnt = 3'(WAIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       abort_q, abort_d;
    logic       accept, rd_done;
    logic       ack_d, ce_n_d, oe_n_d, we_n_d, data_oe_d;
    logic       unused_adr;

    // Byte-offset bits and bits above the SRAM range are deliberately dropped.
    assign unused_adr = ^wb_adr_i;

    assign accept  = (state_q == StIdle) && wb_cyc_i && wb_stb_i;
    assign rd_done = (state_q == StRead) && wb_cyc_i && (cnt_q == LastCnt);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        unique case (state_q)
            StIdle: begin
                cnt_d   = 3'd0;
                abort_d = 1'b0;
                if (wb_cyc_i && wb_stb_i) begin
                    state_d = wb_we_i ? StWrite : StRead;
                end
            end
            StRead: begin
                if (!wb_cyc_i) begin
                    state_d = StIdle;
                end else if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StWrite: begin
                // An aborted write still passes through the hold cycle so data
                // outlives the write strobe.
                if (!wb_cyc_i) begin
                    state_d = StWriteHold;
                    abort_d = 1'b1;
                end else if (cnt_q == LastCnt) begin
                    state_d = StWriteHold;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StWriteHold: state_d = abort_q ? StIdle : StDone;
            StDone:      state_d = StIdle;
            default:     state_d = StIdle;
        endcase

        ack_d     = (state_d == StDone);
        ce_n_d    = !(state_d inside {StRead, StWrite, StWriteHold});
        oe_n_d    = (state_d != StRead);
        we_n_d    = (state_d != StWrite);
        data_oe_d = (state_d inside {StWrite, StWriteHold});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            abort_q      <= 1'b0;
            wb_ack_o     <= 1'b0;
            wb_dat_o     <= '0;
            sram_addr    <= '0;
            sram_data_o  <= '0;
            sram_data_oe <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= '1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
            wb_ack_o     <= ack_d;
            sram_data_oe <= data_oe_d;
            sram_ce_n    <= ce_n_d;
            sram_oe_n    <= oe_n_d;
            sram_we_n    <= we_n_d;
            if (accept) begin
                sram_addr   <= wb_adr_i[SRAM_ADDR_WIDTH+1:2];
                sram_be_n   <= ~wb_sel_i;
                sram_data_o <= wb_dat_i;
            end
            if (rd_done) begin
                wb_dat_o <= sram_data_i;
            end
        end
    end

endmodule
